// File: rtl/reg_file_wq.sv
// -----------------------------------------------------------------------------
// reg_file_wq
//
// Eight-entry, 16-bit general-purpose register file fronted by a two-deep
// write queue. Writes from the execute stage are buffered in a small FIFO and
// committed to the register array one per cycle whenever commit_en is high.
// Per-register busy flags tell the issue logic which registers still have
// writes in flight. The eight register outputs feed the downstream
// register-select mux directly.
//
// Configuration macro:
//   REG_FILE_WQ_ZERO_R0_EN  - when defined, register 0 reads as constant zero.
//                             Writes to index 0 are still queued and still
//                             use a commit slot, but never reach the array,
//                             and busy[0] is tied low.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   wr_valid   in   1   write request valid
//   wr_ready   out  1   queue can accept a write (count < 2)
//   wr_idx     in   3   destination register index
//   wr_dat     in  16   write data
//   commit_en  in   1   array write port available this cycle
//   flush      in   1   synchronous discard of all queued writes
//   reg0..reg7 out 16   committed register contents
//   busy       out  8   bit i set while a queued entry targets register i
//   q_count    out  2   number of queued entries (0..2)
// -----------------------------------------------------------------------------
module reg_file_wq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [2:0]  wr_idx,
    input  logic [15:0] wr_dat,
    input  logic        commit_en,
    input  logic        flush,
    output logic [15:0] reg0,
    output logic [15:0] reg1,
    output logic [15:0] reg2,
    output logic [15:0] reg3,
    output logic [15:0] reg4,
    output logic [15:0] reg5,
    output logic [15:0] reg6,
    output logic [15:0] reg7,
    output logic [7:0]  busy,
    output logic [1:0]  q_count
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    // Queue payload storage. Slots are only read while marked valid by the
    // pointer/count state, so the payload needs no reset.
    logic [2:0]  q_idx_reg [2];
    logic [15:0] q_dat_reg [2];

    logic        head_reg;
    logic        head_next;
    logic        tail_reg;
    logic        tail_next;
    logic [1:0]  count_reg;
    logic [1:0]  count_next;

    // Committed architectural registers.
    logic [15:0] regs_reg [8];

    // -------------------------------------------------------------------------
    // Control decode
    // -------------------------------------------------------------------------
    logic        push;
    logic        pop;
    logic [2:0]  head_idx;
    logic [15:0] head_dat;
    logic [1:0]  slot_valid;
    logic [7:0]  reg_we;

    // Ready is a pure function of the registered count; it deliberately
    // ignores a same-cycle pop so there is no input-to-output path.
    assign wr_ready = (count_reg != 2'd2);

    // Flush wins over both push and pop.
    assign push = wr_valid && wr_ready && !flush;
    assign pop  = commit_en && (count_reg != 2'd0) && !flush;

    assign head_idx = q_idx_reg[head_reg];
    assign head_dat = q_dat_reg[head_reg];

    // A slot holds a live entry if the queue is full, or if it is the head of
    // a one-entry queue.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot_valid
            assign slot_valid[gi] = (count_reg == 2'd2) ||
                                    ((count_reg == 2'd1) && (head_reg == 1'(gi)));
        end
    endgenerate

    // Busy flags and per-register write enables, one decode per register.
    generate
        for (gi = 0; gi < 8; gi++) begin : g_reg_decode
`ifdef REG_FILE_WQ_ZERO_R0_EN
            if (gi == 0) begin : g_zero
                // Index-0 writes drain through the queue but never land.
                assign busy[gi]   = 1'b0;
                assign reg_we[gi] = 1'b0;
            end else begin : g_normal
                assign busy[gi]   = (slot_valid[0] && (q_idx_reg[0] == 3'(gi))) ||
                                    (slot_valid[1] && (q_idx_reg[1] == 3'(gi)));
                assign reg_we[gi] = pop && (head_idx == 3'(gi));
            end
`else
            assign busy[gi]   = (slot_valid[0] && (q_idx_reg[0] == 3'(gi))) ||
                                (slot_valid[1] && (q_idx_reg[1] == 3'(gi)));
            assign reg_we[gi] = pop && (head_idx == 3'(gi));
`endif
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Next-state logic for the queue pointers and occupancy
    // -------------------------------------------------------------------------
    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (flush) begin
            head_next  = 1'b0;
            tail_next  = 1'b0;
            count_next = 2'd0;
        end else begin
            if (pop) begin
                head_next = ~head_reg;
            end
            if (push) begin
                tail_next = ~tail_reg;
            end
            // Simultaneous push and pop leaves the count unchanged.
            case ({push, pop})
                2'b10:   count_next = count_reg + 2'd1;
                2'b01:   count_next = count_reg - 2'd1;
                default: count_next = count_reg;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Sequential state
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg  <= 1'b0;
            tail_reg  <= 1'b0;
            count_reg <= 2'd0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // Payload write at the tail. A push into the slot being popped in the
    // same cycle cannot happen: with one entry the tail is the free slot, and
    // with two entries wr_ready is low.
    always_ff @(posedge clk) begin
        if (push) begin
            q_idx_reg[tail_reg] <= wr_idx;
            q_dat_reg[tail_reg] <= wr_dat;
        end
    end

    // Commit of the head entry into the register array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                regs_reg[i] <= 16'h0000;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (reg_we[i]) begin
                    regs_reg[i] <= head_dat;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign q_count = count_reg;

    // With the zero-register option, regs_reg[0] is never written and so
    // stays at its reset value of zero.
    assign reg0 = regs_reg[0];
    assign reg1 = regs_reg[1];
    assign reg2 = regs_reg[2];
    assign reg3 = regs_reg[3];
    assign reg4 = regs_reg[4];
    assign reg5 = regs_reg[5];
    assign reg6 = regs_reg[6];
    assign reg7 = regs_reg[7];

endmodule

// File: tb/tb_reg_file_wq.sv
// -----------------------------------------------------------------------------
// tb_reg_file_wq
//
// Self-checking bench for reg_file_wq. A behavioural model (queue of pending
// writes plus an array of committed values) tracks the expected state; each
// scenario task drives the DUT and compares against constants or the model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_reg_file_wq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [2:0]  wr_idx = 3'd0;
    logic [15:0] wr_dat = 16'h0000;
    logic        commit_en = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] reg0, reg1, reg2, reg3, reg4, reg5, reg6, reg7;
    logic [7:0]  busy;
    logic [1:0]  q_count;

    reg_file_wq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_idx    (wr_idx),
        .wr_dat    (wr_dat),
        .commit_en (commit_en),
        .flush     (flush),
        .reg0      (reg0),
        .reg1      (reg1),
        .reg2      (reg2),
        .reg3      (reg3),
        .reg4      (reg4),
        .reg5      (reg5),
        .reg6      (reg6),
        .reg7      (reg7),
        .busy      (busy),
        .q_count   (q_count)
    );

    always #5 clk = ~clk;

    logic [15:0] dut_regs [8];
    assign dut_regs[0] = reg0;
    assign dut_regs[1] = reg1;
    assign dut_regs[2] = reg2;
    assign dut_regs[3] = reg3;
    assign dut_regs[4] = reg4;
    assign dut_regs[5] = reg5;
    assign dut_regs[6] = reg6;
    assign dut_regs[7] = reg7;

`ifdef REG_FILE_WQ_ZERO_R0_EN
    localparam bit ZERO_R0 = 1'b1;
`else
    localparam bit ZERO_R0 = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: pending writes in arrival order, and committed values.
    typedef struct packed {
        logic [2:0]  idx;
        logic [15:0] dat;
    } wr_t;
    wr_t         mq [$];
    logic [15:0] mreg [8];

    function automatic logic [7:0] model_busy();
        logic [7:0] b;
        b = 8'h00;
        foreach (mq[k]) b[mq[k].idx] = 1'b1;
        if (ZERO_R0) b[0] = 1'b0;
        return b;
    endfunction

    function automatic void model_clear();
        mq.delete();
        for (int k = 0; k < 8; k++) mreg[k] = 16'h0000;
    endfunction

    // One clock cycle of stimulus; the model advances at the same edge.
    // Called and returns at 1 ns after a rising edge.
    task automatic cycle(input logic v, input logic [2:0] idx, input logic [15:0] dat,
                         input logic ce, input logic fl);
        bit  acc;
        bit  com;
        wr_t e;
        wr_valid  = v;
        wr_idx    = idx;
        wr_dat    = dat;
        commit_en = ce;
        flush     = fl;
        acc = v && (mq.size() < 2) && !fl;
        com = ce && (mq.size() != 0) && !fl;
        @(posedge clk);
        if (fl) begin
            mq.delete();
            $display("t=%0t flush (wr_valid=%0d dropped)", $time, v);
        end else begin
            if (com) begin
                e = mq.pop_front();
                if (!(ZERO_R0 && e.idx == 3'd0)) mreg[e.idx] = e.dat;
                $display("t=%0t commit idx=%0d dat=%h", $time, e.idx, e.dat);
            end
            if (acc) begin
                e.idx = idx;
                e.dat = dat;
                mq.push_back(e);
                $display("t=%0t accept idx=%0d dat=%h", $time, idx, dat);
            end
        end
        #1;
        wr_valid  = 1'b0;
        commit_en = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (dut_regs[k] !== 16'h0000) begin
                errors++;
                $display("FAIL reset_reg%0d: got %h expected 0000", k, dut_regs[k]);
            end
        end
        checks++;
        if (busy !== 8'h00) begin
            errors++; $display("FAIL reset_busy: got %h expected 00", busy);
        end
        checks++;
        if (q_count !== 2'd0) begin
            errors++; $display("FAIL reset_q_count: got %0d expected 0", q_count);
        end
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++; $display("FAIL reset_wr_ready: got %b expected 1", wr_ready);
        end
    endtask

    task automatic test_single();
        cycle(1'b1, 3'd3, 16'hA5A5, 1'b1, 1'b0);
        checks++;
        if (busy !== 8'h08) begin
            errors++; $display("FAIL single_busy_after_N: got %h expected 08", busy);
        end
        checks++;
        if (reg3 !== 16'h0000) begin
            errors++; $display("FAIL single_no_bypass: got %h expected 0000", reg3);
        end
        cycle(1'b0, 3'd0, 16'h0000, 1'b1, 1'b0);
        checks++;
        if (reg3 !== 16'hA5A5) begin
            errors++; $display("FAIL single_reg3: got %h expected a5a5", reg3);
        end
        checks++;
        if (busy !== 8'h00) begin
            errors++; $display("FAIL single_busy_after_N1: got %h expected 00", busy);
        end
    endtask

    task automatic test_backpressure();
        cycle(1'b1, 3'd1, 16'h1111, 1'b0, 1'b0);
        cycle(1'b1, 3'd2, 16'h2222, 1'b0, 1'b0);
        checks++;
        if (q_count !== 2'd2) begin
            errors++; $display("FAIL bp_q_count: got %0d expected 2", q_count);
        end
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++; $display("FAIL bp_wr_ready: got %b expected 0", wr_ready);
        end
        checks++;
        if (busy !== 8'h06) begin
            errors++; $display("FAIL bp_busy: got %h expected 06", busy);
        end
        // Third request while full must be refused.
        cycle(1'b1, 3'd4, 16'h4444, 1'b0, 1'b0);
        checks++;
        if (q_count !== 2'd2 || busy !== 8'h06) begin
            errors++;
            $display("FAIL bp_third_rejected: got q_count=%0d busy=%h expected 2/06", q_count, busy);
        end
        cycle(1'b0, 3'd0, 16'h0000, 1'b1, 1'b0);
        checks++;
        if (reg1 !== 16'h1111 || reg2 !== 16'h0000) begin
            errors++;
            $display("FAIL bp_first_commit: got reg1=%h reg2=%h expected 1111/0000", reg1, reg2);
        end
        cycle(1'b0, 3'd0, 16'h0000, 1'b1, 1'b0);
        checks++;
        if (reg2 !== 16'h2222 || q_count !== 2'd0) begin
            errors++;
            $display("FAIL bp_second_commit: got reg2=%h q_count=%0d expected 2222/0", reg2, q_count);
        end
        checks++;
        if (reg4 !== 16'h0000) begin
            errors++; $display("FAIL bp_reg4_untouched: got %h expected 0000", reg4);
        end
    endtask

    task automatic test_same_idx();
        cycle(1'b1, 3'd5, 16'h0001, 1'b0, 1'b0);
        cycle(1'b1, 3'd5, 16'h0002, 1'b0, 1'b0);
        cycle(1'b0, 3'd0, 16'h0000, 1'b1, 1'b0);
        checks++;
        if (reg5 !== 16'h0001 || busy[5] !== 1'b1) begin
            errors++;
            $display("FAIL same_idx_first: got reg5=%h busy5=%b expected 0001/1", reg5, busy[5]);
        end
        cycle(1'b0, 3'd0, 16'h0000, 1'b1, 1'b0);
        checks++;
        if (reg5 !== 16'h0002 || busy[5] !== 1'b0) begin
            errors++;
            $display("FAIL same_idx_final: got reg5=%h busy5=%b expected 0002/0", reg5, busy[5]);
        end
    endtask

    task automatic test_flush();
        logic [15:0] snap [8];
        cycle(1'b1, 3'd6, 16'h1234, 1'b0, 1'b0);
        cycle(1'b1, 3'd7, 16'h5678, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) snap[k] = mreg[k];
        cycle(1'b1, 3'd4, 16'h9999, 1'b1, 1'b1);
        checks++;
        if (q_count !== 2'd0 || wr_ready !== 1'b1 || busy !== 8'h00) begin
            errors++;
            $display("FAIL flush_full: got q_count=%0d wr_ready=%b busy=%h expected 0/1/00",
                     q_count, wr_ready, busy);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (dut_regs[k] !== snap[k]) begin
                errors++;
                $display("FAIL flush_reg%0d_changed: got %h expected %h", k, dut_regs[k], snap[k]);
            end
        end
        // Flush with one entry: wr_ready is high, write still dropped.
        cycle(1'b1, 3'd6, 16'hAAAA, 1'b0, 1'b0);
        cycle(1'b1, 3'd4, 16'hBBBB, 1'b1, 1'b1);
        cycle(1'b0, 3'd0, 16'h0000, 1'b1, 1'b0);
        checks++;
        if (q_count !== 2'd0 || reg4 !== snap[4] || reg6 !== snap[6]) begin
            errors++;
            $display("FAIL flush_drop: got q_count=%0d reg4=%h reg6=%h expected 0/%h/%h",
                     q_count, reg4, reg6, snap[4], snap[6]);
        end
    endtask

    task automatic test_zero_r0();
        logic        exp_b0;
        logic [15:0] exp_r0;
        exp_b0 = ZERO_R0 ? 1'b0 : 1'b1;
        exp_r0 = ZERO_R0 ? 16'h0000 : 16'hFFFF;
        cycle(1'b1, 3'd0, 16'hFFFF, 1'b0, 1'b0);
        checks++;
        if (q_count !== 2'd1 || busy[0] !== exp_b0) begin
            errors++;
            $display("FAIL r0_queued: got q_count=%0d busy0=%b expected 1/%b", q_count, busy[0], exp_b0);
        end
        cycle(1'b0, 3'd0, 16'h0000, 1'b1, 1'b0);
        checks++;
        if (q_count !== 2'd0 || reg0 !== exp_r0) begin
            errors++;
            $display("FAIL r0_commit: got q_count=%0d reg0=%h expected 0/%h", q_count, reg0, exp_r0);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_busy;
        for (int n = 0; n < 400; n++) begin
            cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
            exp_busy = model_busy();
            checks++;
            if (q_count !== 2'(mq.size()) || busy !== exp_busy ||
                wr_ready !== (mq.size() < 2)) begin
                errors++;
                $display("FAIL rand_ctrl[%0d]: got q_count=%0d busy=%h wr_ready=%b expected %0d/%h/%b",
                         n, q_count, busy, wr_ready, mq.size(), exp_busy, (mq.size() < 2));
            end
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (dut_regs[k] !== mreg[k]) begin
                    errors++;
                    $display("FAIL rand_reg%0d[%0d]: got %h expected %h", k, n, dut_regs[k], mreg[k]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        cycle(1'b1, 3'd1, 16'hC0DE, 1'b0, 1'b0);
        cycle(1'b1, 3'd2, 16'hBEEF, 1'b0, 1'b0);
        // Drop reset between clock edges and look before any edge arrives.
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (q_count !== 2'd0 || busy !== 8'h00 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset_ctrl: got q_count=%0d busy=%h wr_ready=%b expected 0/00/1",
                     q_count, busy, wr_ready);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (dut_regs[k] !== 16'h0000) begin
                errors++;
                $display("FAIL async_reset_reg%0d: got %h expected 0000", k, dut_regs[k]);
            end
        end
        apply_reset();
        cycle(1'b0, 3'd0, 16'h0000, 1'b1, 1'b0);
        checks++;
        if (q_count !== 2'd0 || reg1 !== 16'h0000 || reg2 !== 16'h0000) begin
            errors++;
            $display("FAIL async_reset_data_lost: got q_count=%0d reg1=%h reg2=%h expected 0/0000/0000",
                     q_count, reg1, reg2);
        end
    endtask

    initial begin
        model_clear();
        #3;
        test_reset();
        test_single();
        test_backpressure();
        test_same_idx();
        test_flush();
        test_zero_r0();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
